// File: rtl/irq_vector_sequencer_if.sv
// Memory bus owned by irq_vector_sequencer while a sequence runs.
// Handshake: the master holds mem_addr/mem_wdata/mem_we stable for as long as an access is presented; the access completes on the cycle the slave returns mem_ready=1 (mem_rdata valid in that same cycle).
interface irq_vector_sequencer_if;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/irq_vector_sequencer.sv
// RESET/NMI/BRK/IRQ sequencer: pushes PCH/PCL/P, fetches the vector, hands PC/SP back.
// Define IRQ_SEQ_NMI_EN to enable NMI edge detection and the FFFA vector.
module irq_vector_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        nmi_n,
   input  logic        irq_n,
   input  logic        i_flag,
   input  logic        brk_req,
   input  logic        instr_boundary,
   input  logic [15:0] pc_in,
   input  logic [7:0]  sp_in,
   input  logic [7:0]  status_in,
   irq_vector_sequencer_if.master bus,
   output logic        int_active,
   output logic [15:0] pc_out,
   output logic        pc_load,
   output logic [7:0]  sp_out,
   output logic        sp_load,
   output logic        set_i,
   output logic        int_ack,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, DONE
   } state_t;

   typedef enum logic [1:0] {
      SRC_RESET, SRC_NMI, SRC_BRK, SRC_IRQ
   } src_t;

   state_t      state;
   src_t        src;
   logic [15:0] pc_q;
   logic [7:0]  sp_q;
   logic [7:0]  p_q;
   logic [7:0]  vec_lo;
   logic [15:0] vec_base;
   logic        nmi_pend;
   logic        accept;
   logic        take_nmi;
   logic        take_brk;

   assign accept   = (state == IDLE) && instr_boundary &&
                     (nmi_pend || brk_req || (!irq_n && !i_flag));
   assign take_nmi = accept && nmi_pend;
   assign take_brk = accept && !nmi_pend && brk_req;

`ifdef IRQ_SEQ_NMI_EN
   logic nmi_sync1, nmi_sync2, nmi_prev;

   // An edge that lands mid-sequence simply stays pending until the next boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         nmi_sync1 <= 1'b1;
         nmi_sync2 <= 1'b1;
         nmi_prev  <= 1'b1;
         nmi_pend  <= 1'b0;
      end else begin
         nmi_sync1 <= nmi_n;
         nmi_sync2 <= nmi_sync1;
         nmi_prev  <= nmi_sync2;
         if (nmi_prev && !nmi_sync2)
            nmi_pend <= 1'b1;
         else if (take_nmi)
            nmi_pend <= 1'b0;
      end
   end
`else
   logic unused_nmi_n;
   assign unused_nmi_n = nmi_n;
   assign nmi_pend     = 1'b0;
`endif

   always_comb begin
      vec_base = 16'hFFFE;
      case (src)
         SRC_RESET: vec_base = 16'hFFFC;
`ifdef IRQ_SEQ_NMI_EN
         SRC_NMI:   vec_base = 16'hFFFA;
`endif
         default:   vec_base = 16'hFFFE;
      endcase
   end

   // Bus outputs are forced quiet while reset is held so the first VEC_LO cycle starts clean.
   always_comb begin
      bus.mem_addr  = 16'h0000;
      bus.mem_wdata = 8'h00;
      bus.mem_we    = 1'b0;
      if (!reset) begin
         case (state)
            PUSH_PCH: begin bus.mem_addr = {8'h01, sp_q}; bus.mem_wdata = pc_q[15:8]; bus.mem_we = 1'b1; end
            PUSH_PCL: begin bus.mem_addr = {8'h01, sp_q}; bus.mem_wdata = pc_q[7:0];  bus.mem_we = 1'b1; end
            PUSH_P:   begin bus.mem_addr = {8'h01, sp_q}; bus.mem_wdata = p_q;        bus.mem_we = 1'b1; end
            VEC_LO:   bus.mem_addr = vec_base;
            VEC_HI:   bus.mem_addr = vec_base + 16'd1;
            default:  bus.mem_addr = 16'h0000;
         endcase
      end
   end

   assign int_active = !reset && (state != IDLE);
   assign state_dbg  = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= VEC_LO;
         src     <= SRC_RESET;
         pc_q    <= 16'h0000;
         sp_q    <= 8'h00;
         p_q     <= 8'h00;
         vec_lo  <= 8'h00;
         pc_out  <= 16'h0000;
         pc_load <= 1'b0;
         sp_out  <= 8'h00;
         sp_load <= 1'b0;
         set_i   <= 1'b0;
         int_ack <= 1'b0;
      end else begin
         pc_load <= 1'b0;
         sp_load <= 1'b0;
         set_i   <= 1'b0;
         int_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  int_ack <= 1'b1;
                  src     <= take_nmi ? SRC_NMI : (take_brk ? SRC_BRK : SRC_IRQ);
                  pc_q    <= pc_in;
                  sp_q    <= sp_in;
                  // Pushed P always has bit5 set; B (bit4) marks a software BRK.
                  p_q     <= (status_in & 8'hEF) | 8'h20 | (take_brk ? 8'h10 : 8'h00);
                  state   <= PUSH_PCH;
               end
            end
            PUSH_PCH: if (bus.mem_ready) begin sp_q <= sp_q - 8'd1; state <= PUSH_PCL; end
            PUSH_PCL: if (bus.mem_ready) begin sp_q <= sp_q - 8'd1; state <= PUSH_P;   end
            PUSH_P:   if (bus.mem_ready) begin sp_q <= sp_q - 8'd1; state <= VEC_LO;   end
            VEC_LO:   if (bus.mem_ready) begin vec_lo <= bus.mem_rdata; state <= VEC_HI; end
            VEC_HI: begin
               if (bus.mem_ready) begin
                  pc_out  <= {bus.mem_rdata, vec_lo};
                  pc_load <= 1'b1;
                  set_i   <= 1'b1;
                  if (src != SRC_RESET) begin
                     sp_out  <= sp_q;
                     sp_load <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Directed bench for irq_vector_sequencer: reset vector, IRQ, masking, BRK/NMI priority, wait states, reset abort.
module tb_irq_vector_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        nmi_n = 1'b1;
   logic        irq_n = 1'b1;
   logic        i_flag = 1'b0;
   logic        brk_req = 1'b0;
   logic        instr_boundary = 1'b0;
   logic [15:0] pc_in = 16'h0000;
   logic [7:0]  sp_in = 8'h00;
   logic [7:0]  status_in = 8'h00;
   logic        ready = 1'b1;
   logic        int_active, pc_load, sp_load, set_i, int_ack;
   logic [15:0] pc_out;
   logic [7:0]  sp_out;
   logic [2:0]  state_dbg;

   logic [7:0]  mem [0:65535];
   logic [23:0] exp_q[$];
   logic [23:0] mon_exp;
   int          tests_run = 0;
   int          tests_failed = 0;

   irq_vector_sequencer_if bus ();
   assign bus.mem_rdata = mem[bus.mem_addr];
   assign bus.mem_ready = ready;

   irq_vector_sequencer dut (
      .clk(clk), .reset(reset), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
      .brk_req(brk_req), .instr_boundary(instr_boundary), .pc_in(pc_in),
      .sp_in(sp_in), .status_in(status_in), .bus(bus), .int_active(int_active),
      .pc_out(pc_out), .pc_load(pc_load), .sp_out(sp_out), .sp_load(sp_load),
      .set_i(set_i), .int_ack(int_ack), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // scoreboard: every completed stack write must match the next expected {addr,data}
   always begin
      @(negedge clk);
      #2;
      if (!reset && bus.mem_we && ready) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_write: got %h=%h expected none", bus.mem_addr, bus.mem_wdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_wdata} !== mon_exp) begin
               tests_failed++;
               $display("FAIL stack_write: got %h=%h expected %h=%h", bus.mem_addr, bus.mem_wdata, mon_exp[23:8], mon_exp[7:0]);
            end
         end
      end
   end

   task automatic wait_pc_load(input int limit, output int n);
      n = 0;
      while (pc_load !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({bus.mem_addr, bus.mem_we, int_active, pc_load, sp_load, set_i, int_ack} !== 22'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got addr=%h we=%b act=%b pcl=%b spl=%b expected all 0", bus.mem_addr, bus.mem_we, int_active, pc_load, sp_load);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if (int_active !== 1'b1 || bus.mem_addr !== 16'hFFFC || state_dbg !== 3'd4) begin
         tests_failed++;
         $display("FAIL reset_vec_lo: got act=%b addr=%h st=%0d expected 1 FFFC 4", int_active, bus.mem_addr, state_dbg);
      end
      @(negedge clk);
      tests_run++;
      if (bus.mem_addr !== 16'hFFFD || pc_load !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_vec_hi: got addr=%h pcl=%b expected FFFD 0", bus.mem_addr, pc_load);
      end
      @(negedge clk);
      tests_run++;
      if (pc_load !== 1'b1 || pc_out !== 16'h1234 || set_i !== 1'b1 || sp_load !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got pcl=%b pc=%h seti=%b spl=%b expected 1 1234 1 0", pc_load, pc_out, set_i, sp_load);
      end
      @(negedge clk);
      tests_run++;
      if (int_active !== 1'b0 || pc_load !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: got act=%b pcl=%b expected 0 0", int_active, pc_load);
      end
   endtask

   task automatic test_irq();
      int n;
      pc_in = 16'hC005; sp_in = 8'hFF; status_in = 8'h20;
      i_flag = 1'b0; irq_n = 1'b0; instr_boundary = 1'b1;
      exp_q.push_back({16'h01FF, 8'hC0});
      exp_q.push_back({16'h01FE, 8'h05});
      exp_q.push_back({16'h01FD, 8'h20});
      @(negedge clk);
      instr_boundary = 1'b0; irq_n = 1'b1;
      tests_run++;
      if (int_ack !== 1'b1 || int_active !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_ack: got ack=%b act=%b expected 1 1", int_ack, int_active);
      end
      tests_run++;
      if (bus.mem_addr !== 16'h01FF || bus.mem_we !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_first_access: got addr=%h we=%b expected 01FF 1", bus.mem_addr, bus.mem_we);
      end
      wait_pc_load(10, n);
      tests_run++;
      if (n !== 5 || pc_out !== 16'h8000) begin
         tests_failed++;
         $display("FAIL irq_done: got cycles=%0d pc=%h expected 5 8000", n, pc_out);
      end
      tests_run++;
      if (sp_load !== 1'b1 || sp_out !== 8'hFC || set_i !== 1'b1) begin
         tests_failed++;
         $display("FAIL irq_sp: got spl=%b sp=%h seti=%b expected 1 FC 1", sp_load, sp_out, set_i);
      end
      @(negedge clk);
      tests_run++;
      if (int_active !== 1'b0 || exp_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL irq_end: got act=%b pending=%0d expected 0 0", int_active, exp_q.size());
      end
   endtask

   task automatic test_irq_masked();
      int seen = 0;
      i_flag = 1'b1; irq_n = 1'b0; instr_boundary = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (int_ack !== 1'b0 || int_active !== 1'b0) seen++;
      end
      irq_n = 1'b1; instr_boundary = 1'b0; i_flag = 1'b0;
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL irq_masked: got %0d active cycles expected 0", seen);
      end
   endtask

   task automatic test_brk_nmi();
      int n;
      int acks = 0;
      pc_in = 16'h1234; sp_in = 8'h80; status_in = 8'h00;
      brk_req = 1'b1; irq_n = 1'b0; instr_boundary = 1'b1;
      exp_q.push_back({16'h0180, 8'h12});
      exp_q.push_back({16'h017F, 8'h34});
      exp_q.push_back({16'h017E, 8'h30});
      @(negedge clk);
      instr_boundary = 1'b0; irq_n = 1'b1;
      tests_run++;
      if (int_ack !== 1'b1 || bus.mem_wdata !== 8'h12) begin
         tests_failed++;
         $display("FAIL brk_ack: got ack=%b wdata=%h expected 1 12", int_ack, bus.mem_wdata);
      end
      brk_req = 1'b0;
      nmi_n = 1'b0;
      wait_pc_load(10, n);
      tests_run++;
      if (n !== 5 || pc_out !== 16'h8000 || sp_out !== 8'h7D) begin
         tests_failed++;
         $display("FAIL brk_done: got cycles=%0d pc=%h sp=%h expected 5 8000 7D", n, pc_out, sp_out);
      end
      @(negedge clk);
      pc_in = 16'h2000; sp_in = 8'hFF; status_in = 8'hC3; instr_boundary = 1'b1;
`ifdef IRQ_SEQ_NMI_EN
      exp_q.push_back({16'h01FF, 8'h20});
      exp_q.push_back({16'h01FE, 8'h00});
      exp_q.push_back({16'h01FD, 8'hE3});
      @(negedge clk);
      instr_boundary = 1'b0;
      tests_run++;
      if (int_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL nmi_ack: got %b expected 1", int_ack);
      end
      nmi_n = 1'b1;
      wait_pc_load(10, n);
      tests_run++;
      if (n !== 5 || pc_out !== 16'h9000 || sp_out !== 8'hFC) begin
         tests_failed++;
         $display("FAIL nmi_done: got cycles=%0d pc=%h sp=%h expected 5 9000 FC", n, pc_out, sp_out);
      end
      @(negedge clk);
`else
      repeat (4) begin
         @(negedge clk);
         if (int_ack !== 1'b0 || int_active !== 1'b0) acks++;
      end
      instr_boundary = 1'b0; nmi_n = 1'b1;
      tests_run++;
      if (acks !== 0) begin
         tests_failed++;
         $display("FAIL nmi_ignored: got %0d active cycles expected 0", acks);
      end
`endif
   endtask

   task automatic test_wait_states();
      int n;
      pc_in = 16'hABCD; sp_in = 8'h00; status_in = 8'h01;
      irq_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
      exp_q.push_back({16'h0100, 8'hAB});
      exp_q.push_back({16'h01FF, 8'hCD});
      exp_q.push_back({16'h01FE, 8'h21});
      @(negedge clk);
      instr_boundary = 1'b0; irq_n = 1'b1;
      tests_run++;
      if (int_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL ws_ack: got %b expected 1", int_ack);
      end
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         tests_run++;
         if (bus.mem_addr !== 16'h01FF || bus.mem_wdata !== 8'hCD || state_dbg !== 3'd2) begin
            tests_failed++;
            $display("FAIL ws_hold_c%0d: got addr=%h wdata=%h st=%0d expected 01FF CD 2", c, bus.mem_addr, bus.mem_wdata, state_dbg);
         end
         ready = (c == 5);
      end
      wait_pc_load(10, n);
      tests_run++;
      if (n !== 4 || pc_out !== 16'h8000 || sp_out !== 8'hFD) begin
         tests_failed++;
         $display("FAIL ws_done: got cycles_after_c5=%0d pc=%h sp=%h expected 4 8000 FD", n, pc_out, sp_out);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int n;
      int sp_seen = 0;
      pc_in = 16'h5555; sp_in = 8'h40; status_in = 8'h00;
      irq_n = 1'b0; i_flag = 1'b0; instr_boundary = 1'b1;
      exp_q.push_back({16'h0140, 8'h55});
      exp_q.push_back({16'h013F, 8'h55});
      exp_q.push_back({16'h013E, 8'h20});
      @(negedge clk);
      instr_boundary = 1'b0; irq_n = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (state_dbg !== 3'd4 || bus.mem_addr !== 16'hFFFE) begin
         tests_failed++;
         $display("FAIL abort_vec_lo: got st=%0d addr=%h expected 4 FFFE", state_dbg, bus.mem_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if (state_dbg !== 3'd4 || bus.mem_addr !== 16'hFFFC || int_active !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_restart: got st=%0d addr=%h act=%b expected 4 FFFC 1", state_dbg, bus.mem_addr, int_active);
      end
      n = 0;
      while (pc_load !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
         if (sp_load !== 1'b0) sp_seen++;
      end
      tests_run++;
      if (n !== 2 || pc_out !== 16'h1234) begin
         tests_failed++;
         $display("FAIL abort_done: got cycles=%0d pc=%h expected 2 1234", n, pc_out);
      end
      @(negedge clk);
      tests_run++;
      if (sp_seen !== 0 || sp_load !== 1'b0 || int_active !== 1'b0 || exp_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL abort_end: got sp_pulses=%0d act=%b pending=%0d expected 0 0 0", sp_seen, int_active, exp_q.size());
      end
   endtask

   initial begin
      mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
      mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
      mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
      test_reset();
      test_irq();
      test_irq_masked();
      test_brk_nmi();
      test_wait_states();
      test_reset_abort();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
